// File: rtl/bounce_emulator.sv
// Emulates a bouncing mechanical pushbutton: a requested level change is preceded by
// LFSR-timed ON/OFF bounce pairs, then held for SETTLE_CYCLES before a done pulse.
module bounce_emulator #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cg,
  input  logic       i_valid,
  input  logic       i_level,
  input  logic [3:0] i_nBounces,
  input  logic [7:0] i_widthMask,
  output logic       o_ready,
  output logic       o_button,
  output logic       o_done,
  output logic [1:0] o_dbg_state
);

  // Handshake: a request is taken on a rising edge where i_cg && i_valid && o_ready;
  // o_ready is high only in IDLE and i_valid is ignored everywhere else.

  typedef enum logic [1:0] {IDLE, BOUNCE_ON, BOUNCE_OFF, SETTLE} state_t;

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES);
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  state_t      state_q, state_d;
  logic        button_q, button_d;
  logic        done_q, done_d;
  logic        target_q, target_d;
  logic [3:0]  pairs_q, pairs_d;
  logic [7:0]  mask_q, mask_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] cnt_q, cnt_d;

  logic [7:0]  w_mask;
  logic [8:0]  phase_w;
  logic [15:0] lfsr_adv;
  logic [3:0]  pairs_dec;

  always_comb begin
    // The first phase width is taken at the accept edge, before the mask is registered.
    w_mask    = (state_q == IDLE) ? i_widthMask : mask_q;
    phase_w   = 9'd1 + {1'b0, lfsr_q[7:0] & w_mask};
    lfsr_adv  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    pairs_dec = pairs_q - 4'd1;

    state_d  = state_q;
    button_d = button_q;
    done_d   = done_q;
    target_d = target_q;
    pairs_d  = pairs_q;
    mask_d   = mask_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;

    if (i_cg) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            target_d = i_level;
            mask_d   = i_widthMask;
            pairs_d  = i_nBounces;
            if (i_level == button_q) begin
              done_d = 1'b1;
            end else if (i_nBounces == 4'd0) begin
              state_d  = SETTLE;
              button_d = i_level;
              cnt_d    = SETTLE_LOAD;
            end else begin
              state_d  = BOUNCE_ON;
              button_d = i_level;
              cnt_d    = {7'd0, phase_w};
              lfsr_d   = lfsr_adv;
            end
          end
        end
        BOUNCE_ON: begin
          if (cnt_q == 16'd1) begin
            state_d  = BOUNCE_OFF;
            button_d = ~target_q;
            cnt_d    = {7'd0, phase_w};
            lfsr_d   = lfsr_adv;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        BOUNCE_OFF: begin
          if (cnt_q == 16'd1) begin
            pairs_d  = pairs_dec;
            button_d = target_q;
            if (pairs_dec != 4'd0) begin
              state_d = BOUNCE_ON;
              cnt_d   = {7'd0, phase_w};
              lfsr_d  = lfsr_adv;
            end else begin
              state_d = SETTLE;
              cnt_d   = SETTLE_LOAD;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        SETTLE: begin
          if (cnt_q == 16'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      button_q <= RESET_LEVEL;
      done_q   <= 1'b0;
      target_q <= RESET_LEVEL;
      pairs_q  <= 4'd0;
      mask_q   <= 8'd0;
      lfsr_q   <= LFSR_SEED;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      button_q <= button_d;
      done_q   <= done_d;
      target_q <= target_d;
      pairs_q  <= pairs_d;
      mask_q   <= mask_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_button    = button_q;
  assign o_done      = done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_bounce_emulator.sv
// Directed bench for bounce_emulator: per-cycle vector table plus hand-written
// sequences for LFSR-timed bouncing and asynchronous reset mid-bounce.
module tb_bounce_emulator;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cg;
  logic       valid;
  logic       level;
  logic [3:0] nb;
  logic [7:0] mask;
  logic       ready;
  logic       button;
  logic       done;
  logic [1:0] dbg;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_lfsr;
  logic [8:0]  exp_q[$];

  typedef struct {
    logic       cg;
    logic       valid;
    logic       level;
    logic [3:0] nb;
    logic [7:0] mask;
    int         reps;
    logic       e_button;
    logic       e_ready;
    logic       e_done;
  } vec_t;

  vec_t tbl[$];

  bounce_emulator dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_cg        (cg),
    .i_valid     (valid),
    .i_level     (level),
    .i_nBounces  (nb),
    .i_widthMask (mask),
    .o_ready     (ready),
    .o_button    (button),
    .o_done      (done),
    .o_dbg_state (dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  task automatic add(input logic c, input logic v, input logic l, input logic [3:0] n,
                     input logic [7:0] m, input int r, input logic eb, input logic er,
                     input logic ed);
    vec_t t;
    t.cg = c; t.valid = v; t.level = l; t.nb = n; t.mask = m; t.reps = r;
    t.e_button = eb; t.e_ready = er; t.e_done = ed;
    tbl.push_back(t);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    m_lfsr = SEED;
    #2;
    check("rst_state", dbg, 0);
    check("rst_button", button, 0);
    check("rst_done_ready", {done, ready}, 2'b01);
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Issues one request from IDLE and checks every bounce width against the model LFSR.
  task automatic run_bounce(input logic lv, input logic [3:0] n, input logic [7:0] m,
                            input string tag);
    logic       prev;
    logic       exp_b;
    logic       ok;
    logic [8:0] w;
    int         tr;
    int         cnt;
    for (int i = 0; i < 2 * n; i++) begin
      w = 9'd1 + {1'b0, m_lfsr[7:0] & m};
      exp_q.push_back(w);
      m_lfsr = lfsr_next(m_lfsr);
    end
    cg = 1'b1; valid = 1'b1; level = lv; nb = n; mask = m;
    prev = button;
    tr   = 0;
    step();
    valid = 1'b0;
    if (button !== prev) tr++;
    for (int i = 0; i < 2 * n; i++) begin
      exp_b = (i % 2 == 0) ? lv : ~lv;
      cnt = 0;
      while (button === exp_b && cnt < 300) begin
        cnt++;
        prev = button;
        step();
        if (button !== prev) tr++;
      end
      w = exp_q.pop_front();
      check($sformatf("%s_width%0d", tag, i), cnt, {23'd0, w});
    end
    check($sformatf("%s_transitions", tag), tr, 2 * n + 1);
    ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (button !== lv || done !== 1'b0 || ready !== 1'b0) ok = 1'b0;
      step();
    end
    check($sformatf("%s_settle_hold", tag), ok, 1);
    check($sformatf("%s_done", tag), {done, ready, button}, {1'b1, 1'b1, lv});
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ok;
    int   cnt;
    rst_n = 1'b0; cg = 1'b1; valid = 1'b0; level = 1'b0; nb = 4'd0; mask = 8'd0;
    m_lfsr = SEED;
    #3;
    check("por_state", dbg, 0);
    check("por_outputs", {button, ready, done}, 3'b010);
    step();
    step();
    rst_n = 1'b1;

    // cg valid lvl nb mask reps | button ready done
    add(1, 1, 0, 0, 8'h00,  1, 0, 1, 1);  // level already matches: done next cycle
    add(1, 0, 0, 0, 8'h00,  2, 0, 1, 0);
    add(1, 1, 1, 3, 8'h00,  1, 1, 0, 0);  // 3 pairs of width 1
    add(1, 1, 0, 0, 8'h00,  1, 0, 0, 0);  // valid while busy must be ignored
    add(1, 0, 0, 0, 8'h00,  1, 1, 0, 0);
    add(1, 0, 0, 0, 8'h00,  1, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00,  1, 1, 0, 0);
    add(1, 0, 0, 0, 8'h00,  1, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 16, 1, 0, 0);
    add(1, 0, 0, 0, 8'h00,  1, 1, 1, 1);
    add(1, 0, 0, 0, 8'h00,  1, 1, 1, 0);
    add(1, 1, 0, 0, 8'h00,  1, 0, 0, 0);  // no-bounce release
    add(1, 0, 0, 0, 8'h00, 15, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00,  1, 0, 1, 1);
    add(1, 1, 1, 0, 8'h00,  1, 1, 0, 0);  // no-bounce press
    add(1, 0, 0, 0, 8'h00, 15, 1, 0, 0);
    add(1, 0, 0, 0, 8'h00,  1, 1, 1, 1);
    add(1, 1, 0, 0, 8'h00,  1, 0, 0, 0);  // settle with a 5-cycle gate gap
    add(1, 0, 0, 0, 8'h00,  5, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00,  5, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 10, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00,  1, 0, 1, 1);
    add(0, 1, 1, 0, 8'h00,  3, 0, 1, 1);  // done held while gated, valid not taken
    add(1, 0, 0, 0, 8'h00,  1, 0, 1, 0);

    foreach (tbl[i]) begin
      cg = tbl[i].cg; valid = tbl[i].valid; level = tbl[i].level;
      nb = tbl[i].nb; mask = tbl[i].mask;
      for (int r = 0; r < tbl[i].reps; r++) begin
        step();
        check($sformatf("vec%0d_%0d", i, r), {button, ready, done},
              {tbl[i].e_button, tbl[i].e_ready, tbl[i].e_done});
      end
    end
    cg = 1'b1; valid = 1'b0;

    do_reset();
    run_bounce(1'b1, 4'd15, 8'hFF, "full_mask");

    do_reset();
    run_bounce(1'b1, 4'd0, 8'h00, "pre_press");
    cg = 1'b1; valid = 1'b1; level = 1'b0; nb = 4'd3; mask = 8'h03;
    step();
    valid = 1'b0;
    check("abort_accept", button, 0);
    cnt = 0;
    while (button !== 1'b1 && cnt < 20) begin
      cnt++;
      step();
    end
    check("abort_in_off", dbg, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async_button", button, 0);
    check("abort_async_state", {dbg, ready, done}, 4'b0010);
    m_lfsr = SEED;
    step();
    step();
    rst_n = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done !== 1'b0 || ready !== 1'b1 || button !== 1'b0) ok = 1'b0;
    end
    check("abort_no_done", ok, 1);
    run_bounce(1'b1, 4'd0, 8'h00, "post_press");
    run_bounce(1'b0, 4'd3, 8'hFF, "post_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bounce_emulator.md
BOUNCE_EMULATOR -- requirements
Module: bounce_emulator

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: cycles o_button holds its final level before completion; legal range 1..65535.
REQ-002 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; a zero seed is illegal.
REQ-003 Parameter RESET_LEVEL, default 1'b0: o_button value while reset is asserted.
REQ-004 i_clk  input  1  sole clock; all state on rising edge.
REQ-005 i_rst  input  1  asynchronous, active-low reset.
REQ-006 i_cg  input  1  clock gate; low freezes all state, including the LFSR and counters.
REQ-007 i_valid  input  1  request valid.
REQ-008 i_level  input  1  requested settled button level (1 = pressed).
REQ-009 i_nBounces  input  4  number of bounce pairs (0..15).
REQ-010 i_widthMask  input  8  mask applied to LFSR for phase width.
REQ-011 o_ready  output  1  high only in IDLE.
REQ-012 o_button  output  1  registered emulated noisy button, matching the i_button input of pushbutton.
REQ-013 o_done  output  1  one-cycle completion pulse.

Function
REQ-014 States SHALL be IDLE, BOUNCE_ON, BOUNCE_OFF, SETTLE.
REQ-015 A request SHALL be accepted on a rising edge where i_cg && i_valid && o_ready; target, i_nBounces and i_widthMask are captured at that edge.
REQ-016 i_valid while not in IDLE SHALL be ignored with no effect on state or outputs.
REQ-017 Accept with i_level == o_button SHALL stay in IDLE, leave o_button unchanged and assert o_done in the next cycle.
REQ-018 Accept with i_level != o_button and nBounces == 0 SHALL enter SETTLE with o_button = target in the next cycle.
REQ-019 Accept with i_level != o_button and nBounces > 0 SHALL enter BOUNCE_ON with o_button = target in the next cycle.
REQ-020 In BOUNCE_ON, o_button SHALL equal target.
REQ-021 In BOUNCE_OFF, o_button SHALL equal ~target.
REQ-022 Each BOUNCE phase SHALL last exactly w = 1 + (lfsr[7:0] & widthMask) cycles, with w loaded on phase entry.
REQ-023 Phase width arithmetic SHALL be 9-bit; w ranges 1..256 with no wrap.
REQ-024 The LFSR SHALL be a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (0xB400).
REQ-025 The LFSR SHALL advance exactly once per phase-width load and at no other time.
REQ-026 The BOUNCE_ON -> BOUNCE_OFF transition SHALL occur after w cycles.
REQ-027 BOUNCE_OFF -> BOUNCE_ON SHALL occur after w cycles when the remaining pair count after decrement is > 0; otherwise the next state is SETTLE.
REQ-028 Bounce output SHALL be nBounces ON/OFF pairs, then SETTLE.
REQ-029 SETTLE SHALL hold o_button = target for exactly SETTLE_CYCLES cycles, then enter IDLE.
REQ-030 o_done SHALL be high in the first IDLE cycle after SETTLE and low otherwise, except as in REQ-017.
REQ-031 o_button SHALL be glitch-free, driven directly from a flop.
REQ-032 Gated cycles (i_cg low) SHALL NOT count toward w or SETTLE_CYCLES.
REQ-033 An o_done pulse pending when i_cg falls SHALL persist until the next enabled edge.

Reset
REQ-034 While i_rst == 0, regardless of clock: state = IDLE, o_button = RESET_LEVEL, o_done = 0, o_ready = 1, lfsr = LFSR_SEED, counters = 0.
REQ-035 Reset asserted mid-operation SHALL abandon the request with no o_done pulse.
REQ-036 The first request after reset release SHALL behave identically to a request after power-on.

Verification
REQ-037 Defaults, o_button = 0, accept {level=1, nBounces=0} at edge N -> o_button = 1 from N+1, o_done = 1 only in cycle N+17, o_ready = 0 for N+1..N+16.
REQ-038 Accept {level=1, nBounces=3, widthMask=0} at N -> o_button over N+1..N+6 = 1,0,1,0,1,0, then 1 for 16 cycles, o_done at N+23.
REQ-039 Accept {level=0} with o_button = 0 -> o_button stays 0, o_done at N+1, o_ready stays 1.
REQ-040 widthMask = 8'hFF, nBounces = 15, fixed seed -> every phase width in 1..256 matches a reference-model LFSR sequence, and the o_button transition count is 31 before SETTLE.
REQ-041 i_cg held low 5 cycles mid-SETTLE -> o_done delayed by exactly 5 cycles, o_button unchanged.
REQ-042 i_rst pulsed low during BOUNCE_OFF -> o_button = 0 immediately (asynchronously), no o_done; a new request afterwards reproduces the post-reset LFSR widths.
